// File: rtl/umiram_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : umiram_arbiter_pkg
// Brief    : UMI opcodes, response-rule helper and FSM state for the arbiter.
// Revision : 1.0
// ============================================================================
package umiram_arbiter_pkg;

    localparam logic [4:0] UMI_REQ_READ   = 5'h01;
    localparam logic [4:0] UMI_REQ_WRITE  = 5'h03;
    localparam logic [4:0] UMI_REQ_POSTED = 5'h05;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_t;

    function automatic logic umi_expects_resp(input logic [4:0] opcode);
        return (opcode != UMI_REQ_POSTED);
    endfunction

endpackage
`default_nettype wire

// File: rtl/umiram_arbiter_tagfifo.sv
`default_nettype none
// ============================================================================
// Module   : umiram_arbiter_tagfifo
// Brief    : In-order FIFO of requester IDs awaiting a device response.
// Revision : 1.0
// ============================================================================
module umiram_arbiter_tagfifo
    import umiram_arbiter_pkg::*;
#(
    parameter int IDW   = 1,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         nreset,
    input  logic                         push,
    input  logic [IDW-1:0]               push_id,
    input  logic                         pop,
    output logic [IDW-1:0]               head_id,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);

    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNTW = $clog2(DEPTH + 1);

    logic [IDW-1:0]  r_mem [DEPTH];
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [CNTW-1:0] r_count;
    logic            w_do_push;
    logic            w_do_pop;

    assign full      = (r_count == CNTW'(DEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign head_id   = r_mem[r_rd_ptr];
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
        return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_id;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= next_ptr(r_wr_ptr);
            end
            if (w_do_pop) begin
                r_rd_ptr <= next_ptr(r_rd_ptr);
            end
            // Simultaneous push and pop leaves occupancy unchanged
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + CNTW'(1);
            end else if (!w_do_push && w_do_pop) begin
                r_count <= r_count - CNTW'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/umiram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : umiram_arbiter
// Brief    : Round-robin N:1 UMI request arbiter with in-order response return.
// Revision : 1.0
// ============================================================================
module umiram_arbiter
    import umiram_arbiter_pkg::*;
#(
    parameter int N     = 2,
    parameter int DW    = 256,
    parameter int AW    = 64,
    parameter int CW    = 32,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         nreset,
    input  logic [N-1:0]                 host_req_valid,
    output logic [N-1:0]                 host_req_ready,
    input  logic [N*CW-1:0]              host_req_cmd,
    input  logic [N*AW-1:0]              host_req_dstaddr,
    input  logic [N*AW-1:0]              host_req_srcaddr,
    input  logic [N*DW-1:0]              host_req_data,
    output logic [N-1:0]                 host_resp_valid,
    input  logic [N-1:0]                 host_resp_ready,
    output logic [CW-1:0]                host_resp_cmd,
    output logic [AW-1:0]                host_resp_dstaddr,
    output logic [AW-1:0]                host_resp_srcaddr,
    output logic [DW-1:0]                host_resp_data,
    output logic                         udev_req_valid,
    input  logic                         udev_req_ready,
    output logic [CW-1:0]                udev_req_cmd,
    output logic [AW-1:0]                udev_req_dstaddr,
    output logic [AW-1:0]                udev_req_srcaddr,
    output logic [DW-1:0]                udev_req_data,
    input  logic                         udev_resp_valid,
    output logic                         udev_resp_ready,
    input  logic [CW-1:0]                udev_resp_cmd,
    input  logic [AW-1:0]                udev_resp_dstaddr,
    input  logic [AW-1:0]                udev_resp_srcaddr,
    input  logic [DW-1:0]                udev_resp_data,
    output logic [$clog2(DEPTH+1)-1:0]   outstanding,
    output logic                         err_orphan
);

    localparam int IW   = (N > 1) ? $clog2(N) : 1;
    localparam int CNTW = $clog2(DEPTH + 1);

    logic [CW-1:0]   w_cmd  [N];
    logic [AW-1:0]   w_dst  [N];
    logic [AW-1:0]   w_src  [N];
    logic [DW-1:0]   w_data [N];
    logic [N-1:0]    w_expects;
    logic [N-1:0]    w_elig;

    arb_state_t      r_state;
    arb_state_t      w_state_nxt;
    logic [IW-1:0]   r_rr;
    logic [IW-1:0]   r_lock;
    logic            r_err_orphan;

    logic [IW:0]     w_cand;
    logic [IW-1:0]   w_pick;
    logic            w_pick_found;
    logic [IW-1:0]   w_grant;
    logic            w_gnt_valid;
    logic            w_req_hs;
    logic            w_push;
    logic            w_pop;
    logic [IW-1:0]   w_head;
    logic            w_fifo_full;
    logic            w_fifo_empty;
    logic [CNTW-1:0] w_count;

    generate
        for (genvar i = 0; i < N; i++) begin : g_slice
            assign w_cmd[i]     = host_req_cmd[i*CW +: CW];
            assign w_dst[i]     = host_req_dstaddr[i*AW +: AW];
            assign w_src[i]     = host_req_srcaddr[i*AW +: AW];
            assign w_data[i]    = host_req_data[i*DW +: DW];
            assign w_expects[i] = umi_expects_resp(w_cmd[i][4:0]);
            // Fullness is pre-pop, so a full FIFO blocks reads even on a pop cycle
            assign w_elig[i]    = host_req_valid[i] && (!w_expects[i] || !w_fifo_full);
        end
    endgenerate

    always_comb begin
        w_pick_found = 1'b0;
        w_pick       = '0;
        w_cand       = '0;
        for (int k = 0; k < N; k++) begin
            w_cand = {1'b0, r_rr} + (IW+1)'(k);
            if (w_cand >= (IW+1)'(N)) begin
                w_cand = w_cand - (IW+1)'(N);
            end
            if (!w_pick_found && w_elig[w_cand[IW-1:0]]) begin
                w_pick_found = 1'b1;
                w_pick       = w_cand[IW-1:0];
            end
        end
    end

    // FSM: state register
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM: next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_pick_found && !udev_req_ready) begin
                    w_state_nxt = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                if (udev_req_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        w_grant        = '0;
        w_gnt_valid    = 1'b0;
        host_req_ready = '0;
        case (r_state)
            ST_IDLE: begin
                w_grant     = w_pick;
                w_gnt_valid = w_pick_found;
            end
            ST_LOCKED: begin
                w_grant     = r_lock;
                w_gnt_valid = 1'b1;
            end
            default: begin
                w_grant     = '0;
                w_gnt_valid = 1'b0;
            end
        endcase
        if (w_gnt_valid) begin
            host_req_ready[w_grant] = udev_req_ready;
        end
    end

    assign udev_req_valid   = w_gnt_valid;
    assign udev_req_cmd     = w_cmd[w_grant];
    assign udev_req_dstaddr = w_dst[w_grant];
    assign udev_req_srcaddr = w_src[w_grant];
    assign udev_req_data    = w_data[w_grant];

    assign w_req_hs = w_gnt_valid && udev_req_ready;
    assign w_push   = w_req_hs && w_expects[w_grant];

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_rr         <= '0;
            r_lock       <= '0;
            r_err_orphan <= 1'b0;
        end else begin
            if (w_req_hs) begin
                r_rr <= (w_grant == IW'(N - 1)) ? '0 : w_grant + IW'(1);
            end
            if ((r_state == ST_IDLE) && w_pick_found && !udev_req_ready) begin
                r_lock <= w_pick;
            end
            if (udev_resp_valid && w_fifo_empty) begin
                r_err_orphan <= 1'b1;
            end
        end
    end

    umiram_arbiter_tagfifo #(
        .IDW   (IW),
        .DEPTH (DEPTH)
    ) u_tagfifo (
        .clk     (clk),
        .nreset  (nreset),
        .push    (w_push),
        .push_id (w_grant),
        .pop     (w_pop),
        .head_id (w_head),
        .count   (w_count),
        .full    (w_fifo_full),
        .empty   (w_fifo_empty)
    );

    // Responses with no owner are swallowed so the device never stalls on them
    assign w_pop           = udev_resp_valid && !w_fifo_empty && host_resp_ready[w_head];
    assign udev_resp_ready = udev_resp_valid && (w_fifo_empty || host_resp_ready[w_head]);

    always_comb begin
        host_resp_valid = '0;
        if (udev_resp_valid && !w_fifo_empty) begin
            host_resp_valid[w_head] = 1'b1;
        end
    end

    assign host_resp_cmd     = udev_resp_cmd;
    assign host_resp_dstaddr = udev_resp_dstaddr;
    assign host_resp_srcaddr = udev_resp_srcaddr;
    assign host_resp_data    = udev_resp_data;
    assign outstanding       = w_count;
    assign err_orphan        = r_err_orphan;

endmodule
`default_nettype wire

// File: tb/tb_umiram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_umiram_arbiter
// Brief    : Scoreboard bench for umiram_arbiter with a small in-order device.
// Revision : 1.0
// ============================================================================
module tb_umiram_arbiter;
    import umiram_arbiter_pkg::*;

    localparam int N     = 2;
    localparam int DW    = 64;
    localparam int AW    = 64;
    localparam int CW    = 32;
    localparam int DEPTH = 4;
    localparam int CNTW  = $clog2(DEPTH + 1);

    logic              clk = 1'b0;
    logic              nreset = 1'b0;
    logic [N-1:0]      host_req_valid;
    logic [N-1:0]      host_req_ready;
    logic [N*CW-1:0]   host_req_cmd;
    logic [N*AW-1:0]   host_req_dstaddr;
    logic [N*AW-1:0]   host_req_srcaddr;
    logic [N*DW-1:0]   host_req_data;
    logic [N-1:0]      host_resp_valid;
    logic [N-1:0]      host_resp_ready;
    logic [CW-1:0]     host_resp_cmd;
    logic [AW-1:0]     host_resp_dstaddr;
    logic [AW-1:0]     host_resp_srcaddr;
    logic [DW-1:0]     host_resp_data;
    logic              udev_req_valid;
    logic              udev_req_ready;
    logic [CW-1:0]     udev_req_cmd;
    logic [AW-1:0]     udev_req_dstaddr;
    logic [AW-1:0]     udev_req_srcaddr;
    logic [DW-1:0]     udev_req_data;
    logic              udev_resp_valid;
    logic              udev_resp_ready;
    logic [CW-1:0]     udev_resp_cmd;
    logic [AW-1:0]     udev_resp_dstaddr;
    logic [AW-1:0]     udev_resp_srcaddr;
    logic [DW-1:0]     udev_resp_data;
    logic [CNTW-1:0]   outstanding;
    logic              err_orphan;

    typedef struct {
        logic [DW-1:0] data;
        logic [AW-1:0] dst;
        logic [AW-1:0] src;
    } dev_rsp_t;

    typedef struct {
        int            id;
        logic [DW-1:0] data;
    } exp_rsp_t;

    dev_rsp_t      dev_q[$];
    exp_rsp_t      exp_q[$];
    int            gnt_q[$];
    int            checks = 0;
    int            failures = 0;
    int            resp_credits = 0;
    logic [AW-1:0] src_of  [N];
    logic [AW-1:0] cur_dst [N];

    umiram_arbiter #(
        .N     (N),
        .DW    (DW),
        .AW    (AW),
        .CW    (CW),
        .DEPTH (DEPTH)
    ) dut (
        .clk               (clk),
        .nreset            (nreset),
        .host_req_valid    (host_req_valid),
        .host_req_ready    (host_req_ready),
        .host_req_cmd      (host_req_cmd),
        .host_req_dstaddr  (host_req_dstaddr),
        .host_req_srcaddr  (host_req_srcaddr),
        .host_req_data     (host_req_data),
        .host_resp_valid   (host_resp_valid),
        .host_resp_ready   (host_resp_ready),
        .host_resp_cmd     (host_resp_cmd),
        .host_resp_dstaddr (host_resp_dstaddr),
        .host_resp_srcaddr (host_resp_srcaddr),
        .host_resp_data    (host_resp_data),
        .udev_req_valid    (udev_req_valid),
        .udev_req_ready    (udev_req_ready),
        .udev_req_cmd      (udev_req_cmd),
        .udev_req_dstaddr  (udev_req_dstaddr),
        .udev_req_srcaddr  (udev_req_srcaddr),
        .udev_req_data     (udev_req_data),
        .udev_resp_valid   (udev_resp_valid),
        .udev_resp_ready   (udev_resp_ready),
        .udev_resp_cmd     (udev_resp_cmd),
        .udev_resp_dstaddr (udev_resp_dstaddr),
        .udev_resp_srcaddr (udev_resp_srcaddr),
        .udev_resp_data    (udev_resp_data),
        .outstanding       (outstanding),
        .err_orphan        (err_orphan)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] dev_data(input logic [AW-1:0] dst, input logic [AW-1:0] src);
        return ~dst ^ (src << 8);
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [4:0] op, input logic [AW-1:0] dst);
        host_req_valid[i]             = 1'b1;
        host_req_cmd[i*CW +: CW]      = {27'h0, op};
        host_req_dstaddr[i*AW +: AW]  = dst;
        host_req_srcaddr[i*AW +: AW]  = src_of[i];
        host_req_data[i*DW +: DW]     = {32'hD0D0_0000, dst[31:0]};
        cur_dst[i]                    = dst;
    endtask

    task automatic drop_req(input int i);
        host_req_valid[i] = 1'b0;
    endtask

    task automatic expect_read(input int id, input logic [AW-1:0] dst);
        exp_rsp_t e;
        e.id   = id;
        e.data = dev_data(dst, src_of[id]);
        exp_q.push_back(e);
        gnt_q.push_back(id);
    endtask

    // Counts request handshakes, returning just after the n-th completes
    task automatic run_grants(input int n);
        int seen;
        int cyc;
        seen = 0;
        cyc  = 0;
        while (seen < n && cyc < 50) begin
            @(negedge clk);
            if (udev_req_valid && udev_req_ready) seen++;
            cyc++;
            step();
        end
        if (seen < n) chk("grant_timeout", 64'(seen), 64'(n));
    endtask

    task automatic wait_drain();
        int cyc;
        cyc = 0;
        while ((exp_q.size() > 0 || dev_q.size() > 0 || gnt_q.size() > 0) && cyc < 100) begin
            step();
            cyc++;
        end
        chk("drain", 64'(exp_q.size() + dev_q.size() + gnt_q.size()), 64'd0);
    endtask

    // Grant and response scoreboards, sampled mid-cycle
    always @(negedge clk) begin
        int       id;
        int       e;
        dev_rsp_t d;
        exp_rsp_t x;
        if (nreset) begin
            if (udev_req_valid && udev_req_ready) begin
                id = (host_req_ready == 2'b01) ? 0 : (host_req_ready == 2'b10) ? 1 : 9;
                if (gnt_q.size() == 0) begin
                    chk("gnt_unexpected", 64'd1, 64'd0);
                end else begin
                    e = gnt_q.pop_front();
                    chk("gnt_id", 64'(id), 64'(e));
                    chk("gnt_dst", udev_req_dstaddr, cur_dst[e]);
                end
                if (udev_req_cmd[4:0] != UMI_REQ_POSTED) begin
                    d.data = dev_data(udev_req_dstaddr, udev_req_srcaddr);
                    d.dst  = udev_req_srcaddr;
                    d.src  = udev_req_dstaddr;
                    dev_q.push_back(d);
                end
            end
            if (host_resp_valid != '0) begin
                chk("resp_onehot", 64'($countones(host_resp_valid)), 64'd1);
            end
            for (int i = 0; i < N; i++) begin
                if (host_resp_valid[i] && host_resp_ready[i]) begin
                    if (exp_q.size() == 0) begin
                        chk("resp_unexpected", 64'd1, 64'd0);
                    end else begin
                        x = exp_q.pop_front();
                        chk("resp_id", 64'(i), 64'(x.id));
                        chk("resp_data", host_resp_data, x.data);
                        chk("resp_dst", host_resp_dstaddr, src_of[x.id]);
                    end
                end
            end
            if (udev_resp_valid && udev_resp_ready && dev_q.size() > 0) begin
                dev_q.delete(0);
                if (resp_credits > 0) resp_credits--;
            end
        end
    end

    // In-order device response driver; credits < 0 means unlimited
    initial begin
        udev_resp_valid   = 1'b0;
        udev_resp_cmd     = '0;
        udev_resp_dstaddr = '0;
        udev_resp_srcaddr = '0;
        udev_resp_data    = '0;
        forever begin
            @(posedge clk);
            #2;
            if (resp_credits != 0 && dev_q.size() > 0) begin
                udev_resp_valid   = 1'b1;
                udev_resp_cmd     = 32'h2;
                udev_resp_dstaddr = dev_q[0].dst;
                udev_resp_srcaddr = dev_q[0].src;
                udev_resp_data    = dev_q[0].data;
            end else begin
                udev_resp_valid   = 1'b0;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    initial begin
        host_req_valid   = '0;
        host_req_cmd     = '0;
        host_req_dstaddr = '0;
        host_req_srcaddr = '0;
        host_req_data    = '0;
        host_resp_ready  = '1;
        udev_req_ready   = 1'b0;
        src_of[0]        = 64'h100;
        src_of[1]        = 64'h200;
        cur_dst[0]       = '0;
        cur_dst[1]       = '0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_udev_req_valid", 64'(udev_req_valid), 64'd0);
        chk("rst_host_req_ready", 64'(host_req_ready), 64'd0);
        chk("rst_host_resp_valid", 64'(host_resp_valid), 64'd0);
        chk("rst_udev_resp_ready", 64'(udev_resp_ready), 64'd0);
        chk("rst_outstanding", 64'(outstanding), 64'd0);
        chk("rst_err_orphan", 64'(err_orphan), 64'd0);
        step();
        nreset = 1'b1;
        step();

        // Round-robin alternation with both requesters reading continuously
        udev_req_ready = 1'b1;
        resp_credits   = -1;
        expect_read(0, 64'h10);
        expect_read(1, 64'h20);
        expect_read(0, 64'h10);
        expect_read(1, 64'h20);
        set_req(0, UMI_REQ_READ, 64'h10);
        set_req(1, UMI_REQ_READ, 64'h20);
        run_grants(4);
        drop_req(0);
        drop_req(1);
        wait_drain();
        chk("t1_outstanding", 64'(outstanding), 64'd0);

        // Lock holds requester 1 while the device stalls
        udev_req_ready = 1'b0;
        expect_read(1, 64'h20);
        expect_read(0, 64'h10);
        set_req(1, UMI_REQ_READ, 64'h20);
        @(negedge clk);
        chk("t2_sel_dst", udev_req_dstaddr, 64'h20);
        chk("t2_no_ready", 64'(host_req_ready), 64'd0);
        step();
        set_req(0, UMI_REQ_READ, 64'h10);
        @(negedge clk);
        chk("t2_locked_dst", udev_req_dstaddr, 64'h20);
        chk("t2_locked_valid", 64'(udev_req_valid), 64'd1);
        step();
        @(negedge clk);
        chk("t2_locked_dst2", udev_req_dstaddr, 64'h20);
        step();
        udev_req_ready = 1'b1;
        @(negedge clk);
        chk("t2_ready1", 64'(host_req_ready), 64'b10);
        step();
        drop_req(1);
        @(negedge clk);
        chk("t2_ready0", 64'(host_req_ready), 64'b01);
        chk("t2_dst0", udev_req_dstaddr, 64'h10);
        step();
        drop_req(0);
        wait_drain();

        // Fill the tag FIFO, stall a fifth read, pass a posted write
        resp_credits = 0;
        repeat (4) expect_read(0, 64'h10);
        set_req(0, UMI_REQ_READ, 64'h10);
        run_grants(4);
        @(negedge clk);
        chk("t3_outstanding_full", 64'(outstanding), 64'd4);
        chk("t3_stall_ready", 64'(host_req_ready), 64'd0);
        chk("t3_stall_valid", 64'(udev_req_valid), 64'd0);
        step();
        gnt_q.push_back(1);
        set_req(1, UMI_REQ_POSTED, 64'h30);
        @(negedge clk);
        chk("t3_posted_ready", 64'(host_req_ready), 64'b10);
        step();
        drop_req(1);
        @(negedge clk);
        chk("t3_posted_no_push", 64'(outstanding), 64'd4);

        // Pop on a full FIFO; the blocked read goes through one cycle later
        step();
        expect_read(0, 64'h10);
        resp_credits = 1;
        @(negedge clk);
        chk("t4_resp_valid", 64'(host_resp_valid), 64'b01);
        chk("t4_full_blocks", 64'(udev_req_valid), 64'd0);
        chk("t4_outstanding_4", 64'(outstanding), 64'd4);
        step();
        @(negedge clk);
        chk("t4_outstanding_3", 64'(outstanding), 64'd3);
        chk("t4_grant_after_pop", 64'(host_req_ready), 64'b01);
        step();
        drop_req(0);
        @(negedge clk);
        chk("t4_outstanding_back", 64'(outstanding), 64'd4);
        step();
        resp_credits = -1;
        wait_drain();
        chk("t4_outstanding_empty", 64'(outstanding), 64'd0);

        // Orphan response with an empty tag FIFO
        begin
            dev_rsp_t d;
            d.data = 64'hDEAD_BEEF;
            d.dst  = '0;
            d.src  = '0;
            dev_q.push_back(d);
        end
        @(negedge clk);
        chk("t5_orphan_valid", 64'(udev_resp_valid), 64'd1);
        chk("t5_orphan_ready", 64'(udev_resp_ready), 64'd1);
        chk("t5_orphan_no_host", 64'(host_resp_valid), 64'd0);
        chk("t5_err_before", 64'(err_orphan), 64'd0);
        step();
        @(negedge clk);
        chk("t5_err_set", 64'(err_orphan), 64'd1);
        repeat (3) step();
        chk("t5_err_sticky", 64'(err_orphan), 64'd1);

        // Reset with two reads outstanding; late responses become orphans
        resp_credits = 0;
        gnt_q.push_back(0);
        gnt_q.push_back(0);
        set_req(0, UMI_REQ_READ, 64'h40);
        run_grants(2);
        drop_req(0);
        @(negedge clk);
        chk("t6_outstanding_2", 64'(outstanding), 64'd2);
        #2;
        nreset = 1'b0;
        #1;
        chk("t6_rst_outstanding", 64'(outstanding), 64'd0);
        chk("t6_rst_err", 64'(err_orphan), 64'd0);
        chk("t6_rst_req_valid", 64'(udev_req_valid), 64'd0);
        chk("t6_rst_resp_valid", 64'(host_resp_valid), 64'd0);
        step();
        step();
        nreset = 1'b1;
        resp_credits = -1;
        wait_drain();
        chk("t6_late_orphan", 64'(err_orphan), 64'd1);
        chk("t6_outstanding_end", 64'(outstanding), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
